// File: rtl/aclk_timegen_if.sv
// rtl/aclk_timegen_if.sv - control/status bundle between the watch controller and the time generator
interface aclk_timegen_if;
  logic       reset_count;
  logic       fast_watch;
  logic       one_second;
  logic       one_minute;
  logic [5:0] sec_count;

  modport master (
    output reset_count,
    output fast_watch,
    input  one_second,
    input  one_minute,
    input  sec_count
  );

  modport slave (
    input  reset_count,
    input  fast_watch,
    output one_second,
    output one_minute,
    output sec_count
  );
endinterface

// File: rtl/aclk_timegen.sv
// rtl/aclk_timegen.sv - prescaler producing one-second / one-minute pulses and a 0..59 seconds count
module aclk_timegen #(
  parameter int CLK_PER_SEC = 256
) (
  input  logic          clk,
  input  logic          reset,
  aclk_timegen_if.slave tg
);

  localparam int PW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_SEC - 1);
  localparam logic [5:0]    SEC_MAX = 6'd59;

  logic [PW-1:0] pre;
  logic [5:0]    sec_q;
  logic          fw_d;
  logic          os_q;
  logic          om_q;

  logic tick;
  logic fw_exit;
  logic sec_wrap;

  assign tick     = (pre == PRE_MAX);
  assign fw_exit  = fw_d & ~tg.fast_watch;
  assign sec_wrap = (sec_q == SEC_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre   <= '0;
      sec_q <= '0;
      fw_d  <= 1'b0;
      os_q  <= 1'b0;
      om_q  <= 1'b0;
    end else if (tg.reset_count) begin
      // fw_d keeps tracking the input so a later exit is still seen as an edge
      pre   <= '0;
      sec_q <= '0;
      fw_d  <= tg.fast_watch;
      os_q  <= 1'b0;
      om_q  <= 1'b0;
    end else begin
      fw_d <= tg.fast_watch;
      pre  <= tick ? '0 : pre + 1'b1;
      os_q <= tick;
      if (fw_exit) begin
        // leaving demo mode restarts the minute; the pre-clear count decides a coincident pulse
        sec_q <= '0;
        om_q  <= tick & sec_wrap;
      end else begin
        if (tick) begin
          sec_q <= sec_wrap ? 6'd0 : sec_q + 6'd1;
        end
        om_q <= tick & (tg.fast_watch | sec_wrap);
      end
    end
  end

  assign tg.one_second = os_q;
  assign tg.one_minute = om_q;
  assign tg.sec_count  = sec_q;

  minute_implies_second: assert property (@(posedge clk) disable iff (reset) om_q |-> os_q);

endmodule

// File: doc/aclk_timegen.md
AClK_TIMEGEN -- requirements
Module: aclk_timegen

Interface
REQ-001 SHALL have parameter CLK_PER_SEC, default 256: clk cycles per second; legal range is 2 and above.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port reset_count, input, 1 bit: synchronous restart of the prescaler and seconds count; asserted by control when a new time is loaded.
REQ-005 SHALL have port fast_watch, input, 1 bit: level, 1 = demo mode, where every second counts as one minute.
REQ-006 SHALL have port one_second, output, 1 bit: registered pulse, one clk cycle wide, once per second.
REQ-007 SHALL have port one_minute, output, 1 bit: registered pulse, one clk cycle wide, which feeds the time counter's minute-increment input.
REQ-008 SHALL have port sec_count, output, 6 bits: current seconds value, 0..59, binary.

Function
REQ-009 SHALL hold an internal prescaler pre, $clog2(CLK_PER_SEC) bits wide, with range 0..CLK_PER_SEC-1.
REQ-010 SHALL define tick as the condition pre == CLK_PER_SEC-1, evaluated on current register values.
REQ-011 SHALL, at each clk edge with no reset and no reset_count, set pre to 0 on tick and to pre+1 otherwise; pre never leaves its range.
REQ-012 SHALL register one_second as tick, so one_second is high for exactly the one cycle after the wrap edge.
REQ-013 SHALL, on a tick edge, set sec_count to 0 if it equals 59 and to sec_count+1 otherwise; sec_count SHALL NOT change on non-tick edges.
REQ-014 SHALL, when fast_watch=0, register one_minute as tick AND (sec_count == 59), so one_minute coincides with the one_second that wraps sec_count 59->0.
REQ-015 SHALL, when fast_watch=1, register one_minute as tick, so it is identical to one_second; sec_count keeps counting as in REQ-013.
REQ-016 SHALL sample fast_watch every cycle through a 1-bit delay register fw_d.
REQ-017 SHALL treat a 1->0 transition (fw_d=1, fast_watch=0) as exit, clearing sec_count to 0 on that edge while pre continues counting; the next one_minute follows the 60th subsequent tick.
REQ-018 SHALL apply no special action on a 0->1 transition of fast_watch; the next tick produces one_minute.
REQ-019 SHALL, when reset_count=1 on an edge, set pre, sec_count, one_second and one_minute to 0; holding reset_count high suppresses all pulses.
REQ-020 SHALL, after reset_count is released, produce the first one_second after exactly CLK_PER_SEC edges.
REQ-021 SHALL apply priority per edge, highest first: reset, reset_count, fast_watch exit, normal count.
REQ-022 SHALL not let a tick coinciding with reset_count or fast_watch exit increment sec_count; when fast_watch exit coincides with a tick, one_minute uses the fast_watch=0 rule (REQ-014) with the pre-clear sec_count.
REQ-023 SHALL never assert one_minute without one_second in the same cycle.

Reset
REQ-024 SHALL, with reset=1 at a clk edge, set pre, sec_count, fw_d, one_second and one_minute to 0 regardless of other inputs.
REQ-025 SHALL, after reset is released, produce the first one_second after exactly CLK_PER_SEC edges and the first one_minute (fast_watch=0) after 60*CLK_PER_SEC edges.
REQ-026 SHALL, when reset is asserted mid-second or mid-minute, abandon the partial count with no pulse emitted.

Verification (CLK_PER_SEC=4)
REQ-027 SHALL cover power-up: reset for 3 cycles, then release -> outputs 0; one_second high only in cycle 4 after release; sec_count=1 afterwards.
REQ-028 SHALL cover normal minute: fast_watch=0 for 500 cycles -> one_second every 4 cycles; one_minute at cycles 240 and 480 only, each with one_second high; sec_count 59->0 at those points.
REQ-029 SHALL cover fast mode: fast_watch=1 -> one_minute equals one_second cycle-for-cycle, a pulse every 4 cycles.
REQ-030 SHALL cover fast exit: fast_watch 1->0 when sec_count=17 -> sec_count=0 the next cycle; next one_minute exactly at the 60th following one_second.
REQ-031 SHALL cover restart: reset_count pulsed when pre=2, sec_count=30 -> pre=0 and sec_count=0; next one_second 4 edges later; reset_count held for 20 cycles -> no pulses.
REQ-032 SHALL cover priority: reset and reset_count together with fast_watch toggling -> reset values of REQ-024; reset_count coincident with a tick -> no pulse, sec_count=0.
